// File: rtl/truth_table_sequencer.sv
// Sweeps a 3-input combinational block through vectors 000..111 and captures its truth table.
// Optional EXPECT_CHECK_EN adds an expected-table input and a registered match flag.
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       inA,
  output logic       inB,
  output logic       inC,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out
`ifdef EXPECT_CHECK_EN
  ,
  input  logic [7:0] expected,
  output logic       match
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tbl_q, tbl_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tbl_d   = 8'h00;
          idx_d   = 3'd0;
          cnt_d   = SETTLE;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // cnt_q==1 marks the last settle cycle of this vector
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        tbl_d[idx_q] = y_in;
        if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = SETTLE;
          state_d = S_DRIVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inA       = idx_q[2];
  assign inB       = idx_q[1];
  assign inC       = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = tbl_q;

`ifdef EXPECT_CHECK_EN
  logic match_q, match_d;

  // Table is final while in DONE; the verdict then holds until the next accepted start.
  always_comb begin
    match_d = match_q;
    if (state_q == S_IDLE && start) match_d = 1'b0;
    else if (state_q == S_DONE)     match_d = (tbl_q == expected);
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: two sequencers (SETTLE_CYCLES 2 and 1) sweeping modelled truth tables.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic [7:0] f0, f1;
  logic       inA0, inB0, inC0, busy0, done0;
  logic       inA1, inB1, inC1, busy1, done1;
  logic [7:0] tbl0, tbl1;
  logic       y0, y1;
  logic       sel;

  assign y0 = f0[{inA0, inB0, inC0}];
  assign y1 = f1[{inA1, inB1, inC1}];

`ifdef EXPECT_CHECK_EN
  logic [7:0] exp0, exp1;
  logic       match0, match1;
`endif

  truth_table_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start0), .y_in(y0),
    .inA(inA0), .inB(inB0), .inC(inC0), .busy(busy0), .done(done0), .table_out(tbl0)
`ifdef EXPECT_CHECK_EN
    , .expected(exp0), .match(match0)
`endif
  );

  truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1),
    .inA(inA1), .inB(inB1), .inC(inC1), .busy(busy1), .done(done1), .table_out(tbl1)
`ifdef EXPECT_CHECK_EN
    , .expected(exp1), .match(match1)
`endif
  );

  wire [2:0] vec_s  = sel ? {inA1, inB1, inC1} : {inA0, inB0, inC0};
  wire       busy_s = sel ? busy1 : busy0;
  wire       done_s = sel ? done1 : done0;
  wire [7:0] tbl_s  = sel ? tbl1 : tbl0;

  int vectors = 0;
  int errs    = 0;

  // Reference: the captured table is the block's output for vector i placed at bit i.
  function automatic logic [7:0] model_table(input int op);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int a, b, c;
      a = (i >> 2) & 1; b = (i >> 1) & 1; c = i & 1;
      if (op == 0) t[i] = 1'((a + b + c) % 2);
      else         t[i] = 1'(a * b * c);
    end
    return t;
  endfunction

  task automatic set_start(input bit v);
    if (sel) start1 = v; else start0 = v;
  endtask

  // Cycle n = n-th falling edge after the edge that accepted start.
  // Expected: done only at 8*(S+1)+1, busy in cycles 1..8*(S+1), vectors 0..7 in order.
  task automatic sweep(input bit s, input logic [7:0] f, input bit hold, input string tag);
    int S, lat, busy_n, done_n, done_at;
    logic [2:0] seq[$];
    sel = s;
    S   = s ? 1 : 2;
    lat = 8 * (S + 1) + 1;
    busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    if (s) f1 = f; else f0 = f;
    set_start(1'b1);
    @(posedge clk);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) set_start(1'b0);
      if (busy_s) begin
        busy_n++;
        if (seq.size() == 0 || seq[$] != vec_s) seq.push_back(vec_s);
      end
      if (done_s) begin done_n++; done_at = n; end
    end
    vectors++;
    if (done_at !== lat || done_n !== 1) begin
      errs++;
      $display("FAIL %s done_cycle: got %0d (pulses %0d) want %0d (pulses 1)", tag, done_at, done_n, lat);
    end
    vectors++;
    if (busy_n !== lat - 1) begin
      errs++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, lat - 1);
    end
    vectors++;
    if (seq.size() !== 8) begin
      errs++; $display("FAIL %s vector_count: got %0d want 8", tag, seq.size());
    end else begin
      for (int i = 0; i < 8; i++)
        if (seq[i] !== 3'(i)) begin
          errs++; $display("FAIL %s vector_order[%0d]: got %0d want %0d", tag, i, seq[i], i);
          break;
        end
    end
    vectors++;
    if (tbl_s !== f) begin
      errs++; $display("FAIL %s table: got %h want %h", tag, tbl_s, f);
    end
    if (hold) begin
      // cycle lat+1 is the one IDLE cycle; start still high is taken at its closing edge
      vectors++;
      if (busy_s !== 1'b0 || done_s !== 1'b0) begin
        errs++; $display("FAIL %s idle_gap: got busy=%b done=%b want 0 0", tag, busy_s, done_s);
      end
      @(negedge clk);
      set_start(1'b0);
      vectors++;
      if (busy_s !== 1'b1 || tbl_s !== 8'h00) begin
        errs++; $display("FAIL %s restart: got busy=%b table=%h want 1 00", tag, busy_s, tbl_s);
      end
      done_n = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (done_s) done_n++;
      end
      vectors++;
      if (done_n !== 1 || tbl_s !== f) begin
        errs++; $display("FAIL %s second_sweep: got pulses=%0d table=%h want 1 %h", tag, done_n, tbl_s, f);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if ({inA0, inB0, inC0, busy0, done0} !== 5'b0 || tbl0 !== 8'h00 ||
        {inA1, inB1, inC1, busy1, done1} !== 5'b0 || tbl1 !== 8'h00) begin
      errs++;
      $display("FAIL %s: got dut0 abc=%b%b%b busy=%b done=%b tbl=%h dut1 abc=%b%b%b busy=%b done=%b tbl=%h want all 0",
               tag, inA0, inB0, inC0, busy0, done0, tbl0, inA1, inB1, inC1, busy1, done1, tbl1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; f0 = 8'h00; f1 = 8'h00; sel = 1'b0;
`ifdef EXPECT_CHECK_EN
    exp0 = 8'h00; exp1 = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_xor3();
    sweep(1'b0, model_table(0), 1'b0, "xor3");
  endtask

  task automatic test_and3_settle1();
    sweep(1'b1, model_table(1), 1'b0, "and3_s1");
  endtask

  task automatic test_idle_hold();
    logic [7:0] f;
    f = 8'($urandom);
    sweep(1'b0, f, 1'b0, "hold_sweep");
    repeat (5) @(negedge clk);
    vectors++;
    if (tbl0 !== f || {inA0, inB0, inC0} !== 3'b111 || busy0 !== 1'b0) begin
      errs++; $display("FAIL idle_hold: got tbl=%h abc=%b%b%b busy=%b want %h 111 0", tbl0, inA0, inB0, inC0, busy0, f);
    end
  endtask

  task automatic test_start_held();
    sweep(1'b0, 8'($urandom), 1'b1, "start_held");
  endtask

  task automatic test_mid_reset();
    int pulses;
    sel = 1'b0;
    @(negedge clk);
    f0 = 8'($urandom);
    start0 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done0 || busy0) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errs++; $display("FAIL mid_reset_quiet: got %0d busy/done cycles want 0", pulses);
    end
  endtask

  task automatic test_rst_priority();
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    check_zero("rst_priority");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(1'($urandom), 8'($urandom), 1'b0, "random");
    end
  endtask

`ifdef EXPECT_CHECK_EN
  task automatic test_match();
    exp0 = 8'h96;
    sweep(1'b0, model_table(0), 1'b0, "match_ok");
    vectors++;
    if (match0 !== 1'b1) begin errs++; $display("FAIL match_96: got %b want 1", match0); end
    exp0 = 8'h97;
    sweep(1'b0, model_table(0), 1'b0, "match_bad");
    vectors++;
    if (match0 !== 1'b0) begin errs++; $display("FAIL match_97: got %b want 0", match0); end
  endtask
`endif

  initial begin
    test_reset();
    test_xor3();
    test_and3_settle1();
    test_idle_hold();
    test_start_held();
    test_mid_reset();
    test_rst_priority();
    test_random();
`ifdef EXPECT_CHECK_EN
    test_match();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, cycles each input vector is held before Y is sampled; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-005 SHALL have port: y_in  input  1  output of the combinational block under test.
REQ-006 SHALL have port: inA  output  1  stimulus MSB, equal to idx[2].
REQ-007 SHALL have port: inB  output  1  stimulus, equal to idx[1].
REQ-008 SHALL have port: inC  output  1  stimulus LSB, equal to idx[0].
REQ-009 SHALL have port: busy  output  1  high in DRIVE and SAMPLE states.
REQ-010 SHALL have port: done  output  1  single-cycle pulse when the sweep completes.
REQ-011 SHALL have port: table_out  output  8  captured truth table; bit i = y_in sampled for vector i.

Function
REQ-012 SHALL implement states IDLE, DRIVE, SAMPLE, DONE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1, clear table_out to 8'h00, set idx=0, load settle counter, and enter DRIVE next cycle.
REQ-014 SHALL hold {inA,inB,inC}=idx stable for exactly SETTLE_CYCLES cycles in DRIVE, then enter SAMPLE.
REQ-015 SHALL, in SAMPLE, write table_out[idx] <= y_in; if idx==7 enter DONE, else idx+1, reload counter, enter DRIVE.
REQ-016 SHALL spend 1 cycle in DONE with done=1, then return to IDLE; done low in all other states.
REQ-017 SHALL assert done exactly 8*(SETTLE_CYCLES+1)+1 cycles after the edge on which start was accepted (25 for default).
REQ-018 SHALL ignore start while busy=1 or in DONE; no restart, no table clear.
REQ-019 SHALL hold table_out and {inA,inB,inC} unchanged in IDLE after a sweep until the next accepted start.
REQ-020 SHALL present vectors in ascending order 000..111 without skips or repeats; idx SHALL not wrap past 7 within a sweep.
REQ-021 SHALL accept a start asserted in the first IDLE cycle after DONE (back-to-back sweeps, one idle cycle minimum).

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force state=IDLE, idx=0, inA=inB=inC=0, busy=0, done=0, table_out=8'h00, counter=0.
REQ-023 SHALL abort a sweep when rst asserts mid-operation; no done pulse for the aborted sweep.
REQ-024 SHALL give rst priority over start when both are high in the same cycle.

Configuration
REQ-025 SHALL, with EXPECT_CHECK_EN defined, add input expected[7:0] and output match (1 bit), where match is registered in DONE as (table_out_final == expected), held until next accepted start, cleared by reset and at start.
REQ-026 SHALL, without EXPECT_CHECK_EN, have no expected/match ports and no comparator logic; all other behaviour identical.

Verification
REQ-027 SHALL verify: y_in = inA^inB^inC, start pulse -> done at cycle 25, table_out=8'h96, busy high 24 cycles.
REQ-028 SHALL verify: y_in = inA&inB&inC, SETTLE_CYCLES=1 -> done at cycle 17, table_out=8'h80; vector sequence 000..111 observed on inA/inB/inC.
REQ-029 SHALL verify: start held high for whole sweep -> exactly one done pulse, table unchanged; second sweep starts only in first IDLE cycle after DONE.
REQ-030 SHALL verify: rst asserted at cycle 10 of sweep -> next cycle all outputs zero, state IDLE, no done pulse.
REQ-031 SHALL verify (EXPECT_CHECK_EN): XOR3 block, expected=8'h96 -> match=1; expected=8'h97 -> match=0.
